tl_master_cmd_engine: RTL

- Synthesizable, parametrised TileLink-UL/UH master. Successor to the behavioural per-core TL master used in tile replacements.
- Converts a simple command/response interface into single-beat A-channel Get/PutFull/PutPartial requests.
- Tracks up to 2^SRC_SIZE outstanding transactions by source ID and returns D-channel responses in completion order.
- B, C and E channels are tied off, so the block drops directly into a tile slot or a DMA-style test master.

---
 rtl/tl_master_cmd_pkg.sv | 27 ++
 rtl/tl_src_id_pool.sv | 111 +++++++++++
 rtl/tl_master_cmd_engine.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tl_master_cmd_pkg.sv
// Shared TileLink opcodes, A-request header type and lane-mask helper for the
// command-driven TL-UL master.
package tl_master_cmd_pkg;

    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] PUTFULL       = 3'd0;
    localparam logic [2:0] PUTPARTIAL    = 3'd1;
    localparam logic [2:0] ACCESSACK     = 3'd0;
    localparam logic [2:0] ACCESSACKDATA = 3'd1;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] size;
    } tl_a_req_t;

    // Lanes touched by a naturally aligned 2^size access; sized for a 32-byte bus.
    function automatic logic [31:0] full_mask(input logic [3:0] size, input logic [4:0] off);
        logic [5:0]  lanes;
        logic [5:0]  base;
        logic [63:0] m;
        lanes = 6'd1 << size[2:0];
        base  = {1'b0, off} & ~(lanes - 6'd1);
        m     = ((64'd1 << lanes) - 64'd1) << base;
        return m[31:0];
    endfunction

endpackage

// File: rtl/tl_src_id_pool.sv
// Source-ID pool: free bitmap, lowest-free encoder, in-flight count and, with
// TL_MASTER_CMD_TIMEOUT_EN defined, per-ID saturating age counters.
module tl_src_id_pool
    import tl_master_cmd_pkg::*;
#(
    parameter int SRC_SIZE       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_alloc,
    input  logic                     i_alloc_is_get,
    input  logic                     i_free,
    input  logic [SRC_SIZE-1:0]      i_free_id,
    output logic [SRC_SIZE-1:0]      o_free_id,
    output logic                     o_any_free,
    output logic [(1<<SRC_SIZE)-1:0] o_busy,
    output logic [(1<<SRC_SIZE)-1:0] o_is_get,
`ifdef TL_MASTER_CMD_TIMEOUT_EN
    output logic                     o_err_timeout,
    output logic [SRC_SIZE-1:0]      o_err_timeout_tag,
`endif
    output logic [SRC_SIZE:0]        o_outstanding
);

    localparam int NID = 1 << SRC_SIZE;

    logic [NID-1:0]      r_busy;
    logic [NID-1:0]      r_is_get;
    logic [SRC_SIZE:0]   r_outstanding;
    logic [SRC_SIZE-1:0] w_free_id;
    logic [NID-1:0]      w_alloc_oh;
    logic [NID-1:0]      w_free_oh;

    always_comb begin
        w_free_id = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_id = SRC_SIZE'(i);
        end
    end

    assign w_alloc_oh = i_alloc ? (NID'(1) << w_free_id) : '0;
    assign w_free_oh  = i_free  ? (NID'(1) << i_free_id) : '0;

    // Freed IDs only become visible to the encoder next cycle, since it reads r_busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy        <= '0;
            r_is_get      <= '0;
            r_outstanding <= '0;
        end else begin
            r_busy <= (r_busy | w_alloc_oh) & ~w_free_oh;
            if (i_alloc) r_is_get[w_free_id] <= i_alloc_is_get;
            case ({i_alloc, i_free})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign o_free_id     = w_free_id;
    assign o_any_free    = ~&r_busy;
    assign o_busy        = r_busy;
    assign o_is_get      = r_is_get;
    assign o_outstanding = r_outstanding;

`ifdef TL_MASTER_CMD_TIMEOUT_EN
    localparam int                AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    logic [AGE_W-1:0]    r_age [NID];
    logic                r_err_timeout;
    logic [SRC_SIZE-1:0] r_err_tag;
    logic                w_hit;
    logic [SRC_SIZE-1:0] w_hit_id;

    // An ID answered on the very cycle it would expire is not flagged.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (r_busy[i] && !w_free_oh[i] && r_age[i] == AGE_MAX - 1'b1) begin
                w_hit    = 1'b1;
                w_hit_id = SRC_SIZE'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NID; i++) r_age[i] <= '0;
            r_err_timeout <= 1'b0;
            r_err_tag     <= '0;
        end else begin
            for (int i = 0; i < NID; i++) begin
                if (w_alloc_oh[i])                         r_age[i] <= '0;
                else if (r_busy[i] && r_age[i] != AGE_MAX) r_age[i] <= r_age[i] + 1'b1;
            end
            if (!r_err_timeout && w_hit) begin
                r_err_timeout <= 1'b1;
                r_err_tag     <= w_hit_id;
            end
        end
    end

    assign o_err_timeout     = r_err_timeout;
    assign o_err_timeout_tag = r_err_tag;
`endif

endmodule

// File: rtl/tl_master_cmd_engine.sv
// Command/response to TileLink-UL single-beat master; B/C/E tied off.
// Optional response timeout tracking is enabled by TL_MASTER_CMD_TIMEOUT_EN.
module tl_master_cmd_engine
    import tl_master_cmd_pkg::*;
#(
    parameter int SRC_SIZE       = 2,
    parameter int SINK_SIZE      = 2,
    parameter int BUS_SIZE       = 8,
    parameter int ADR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [3:0]              cmd_size,
    input  logic [ADR_WIDTH-1:0]    cmd_addr,
    input  logic [BUS_SIZE-1:0]     cmd_mask,
    input  logic [8*BUS_SIZE-1:0]   cmd_data,
    output logic [SRC_SIZE-1:0]     cmd_tag,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SRC_SIZE-1:0]     rsp_tag,
    output logic [8*BUS_SIZE-1:0]   rsp_data,
    output logic                    rsp_denied,
    output logic                    rsp_corrupt,
    output logic                    tl_a_valid,
    input  logic                    tl_a_ready,
    output logic [2:0]              tl_a_opcode,
    output logic [2:0]              tl_a_param,
    output logic [3:0]              tl_a_size,
    output logic [SRC_SIZE-1:0]     tl_a_source,
    output logic [ADR_WIDTH-1:0]    tl_a_address,
    output logic [BUS_SIZE-1:0]     tl_a_mask,
    output logic [8*BUS_SIZE-1:0]   tl_a_data,
    output logic                    tl_a_corrupt,
    output logic                    tl_b_ready,
    input  logic                    tl_b_valid,
    input  logic [1:0]              tl_b_param,
    input  logic [3:0]              tl_b_size,
    input  logic [SRC_SIZE-1:0]     tl_b_source,
    input  logic [ADR_WIDTH-1:0]    tl_b_address,
    output logic                    tl_c_valid,
    input  logic                    tl_c_ready,
    output logic [2:0]              tl_c_opcode,
    output logic [2:0]              tl_c_param,
    output logic [3:0]              tl_c_size,
    output logic [SRC_SIZE-1:0]     tl_c_source,
    output logic [ADR_WIDTH-1:0]    tl_c_address,
    output logic [8*BUS_SIZE-1:0]   tl_c_data,
    output logic                    tl_c_corrupt,
    input  logic                    tl_d_valid,
    output logic                    tl_d_ready,
    input  logic [2:0]              tl_d_opcode,
    input  logic [1:0]              tl_d_param,
    input  logic [3:0]              tl_d_size,
    input  logic [SRC_SIZE-1:0]     tl_d_source,
    input  logic [SINK_SIZE-1:0]    tl_d_sink,
    input  logic                    tl_d_denied,
    input  logic [8*BUS_SIZE-1:0]   tl_d_data,
    input  logic                    tl_d_corrupt,
    output logic                    tl_e_valid,
    input  logic                    tl_e_ready,
    output logic [SINK_SIZE-1:0]    tl_e_bits_sink,
    output logic [SRC_SIZE:0]       outstanding,
    output logic                    idle,
`ifdef TL_MASTER_CMD_TIMEOUT_EN
    output logic                    err_timeout,
    output logic [SRC_SIZE-1:0]     err_timeout_tag,
`endif
    output logic                    err_unexpected_d,
    output logic                    err_opcode
);

    localparam int NID   = 1 << SRC_SIZE;
    localparam int OFF_W = $clog2(BUS_SIZE);

    logic                  w_any_free;
    logic [SRC_SIZE-1:0]   w_free_id;
    logic [NID-1:0]        w_busy;
    logic [NID-1:0]        w_is_get;
    logic                  w_cmd_fire;
    logic [31:0]           w_fm;
    logic [31:0]           w_mask32;
    logic                  w_full_cover;
    logic                  w_d_fire;
    logic                  w_d_known;
    logic                  w_d_is_get;
    logic [2:0]            w_d_expect;
    logic                  w_unused_inputs;

    tl_a_req_t             r_a_hdr;
    logic                  r_a_valid;
    logic [SRC_SIZE-1:0]   r_a_source;
    logic [ADR_WIDTH-1:0]  r_a_addr;
    logic [BUS_SIZE-1:0]   r_a_mask;
    logic [8*BUS_SIZE-1:0] r_a_data;
    logic                  r_rsp_valid;
    logic [SRC_SIZE-1:0]   r_rsp_tag;
    logic [8*BUS_SIZE-1:0] r_rsp_data;
    logic                  r_rsp_denied;
    logic                  r_rsp_corrupt;
    logic                  r_err_unexp;
    logic                  r_err_op;

    assign cmd_ready  = w_any_free && (!r_a_valid || tl_a_ready);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign cmd_tag    = w_free_id;

    assign w_fm         = full_mask(cmd_size, 5'(cmd_addr[OFF_W-1:0]));
    assign w_mask32     = 32'(cmd_mask);
    assign w_full_cover = (w_mask32 & w_fm) == w_fm;

    assign tl_d_ready = !r_rsp_valid || rsp_ready;
    assign w_d_fire   = tl_d_valid && tl_d_ready;
    assign w_d_known  = w_busy[tl_d_source];
    assign w_d_is_get = w_is_get[tl_d_source];
    assign w_d_expect = w_d_is_get ? ACCESSACKDATA : ACCESSACK;

    tl_src_id_pool #(
        .SRC_SIZE       (SRC_SIZE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_pool (
        .i_clk             (clock),
        .i_rst_n           (reset_n),
        .i_alloc           (w_cmd_fire),
        .i_alloc_is_get    (!cmd_write),
        .i_free            (w_d_fire && w_d_known),
        .i_free_id         (tl_d_source),
        .o_free_id         (w_free_id),
        .o_any_free        (w_any_free),
        .o_busy            (w_busy),
        .o_is_get          (w_is_get),
`ifdef TL_MASTER_CMD_TIMEOUT_EN
        .o_err_timeout     (err_timeout),
        .o_err_timeout_tag (err_timeout_tag),
`endif
        .o_outstanding     (outstanding)
    );

    // A-channel holding register: loaded on cmd fire, held until tl_a_ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a_valid  <= 1'b0;
            r_a_hdr    <= '0;
            r_a_source <= '0;
            r_a_addr   <= '0;
            r_a_mask   <= '0;
            r_a_data   <= '0;
        end else if (w_cmd_fire) begin
            r_a_valid      <= 1'b1;
            r_a_hdr.opcode <= !cmd_write ? GET : (w_full_cover ? PUTFULL : PUTPARTIAL);
            r_a_hdr.size   <= cmd_size;
            r_a_source     <= w_free_id;
            r_a_addr       <= cmd_addr;
            r_a_mask       <= cmd_write ? BUS_SIZE'(w_mask32 & w_fm) : BUS_SIZE'(w_fm);
            r_a_data       <= cmd_write ? cmd_data : '0;
        end else if (tl_a_ready) begin
            r_a_valid <= 1'b0;
        end
    end

    // D-channel response register and sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_tag     <= '0;
            r_rsp_data    <= '0;
            r_rsp_denied  <= 1'b0;
            r_rsp_corrupt <= 1'b0;
            r_err_unexp   <= 1'b0;
            r_err_op      <= 1'b0;
        end else begin
            if (w_d_fire && w_d_known) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_tag     <= tl_d_source;
                r_rsp_data    <= w_d_is_get ? tl_d_data : '0;
                r_rsp_denied  <= tl_d_denied;
                r_rsp_corrupt <= tl_d_corrupt;
                if (tl_d_opcode != w_d_expect) r_err_op <= 1'b1;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_d_fire && !w_d_known) r_err_unexp <= 1'b1;
        end
    end

    assign tl_a_valid   = r_a_valid;
    assign tl_a_opcode  = r_a_hdr.opcode;
    assign tl_a_param   = 3'd0;
    assign tl_a_size    = r_a_hdr.size;
    assign tl_a_source  = r_a_source;
    assign tl_a_address = r_a_addr;
    assign tl_a_mask    = r_a_mask;
    assign tl_a_data    = r_a_data;
    assign tl_a_corrupt = 1'b0;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_tag     = r_rsp_tag;
    assign rsp_data    = r_rsp_data;
    assign rsp_denied  = r_rsp_denied;
    assign rsp_corrupt = r_rsp_corrupt;

    assign tl_b_ready     = 1'b1;
    assign tl_c_valid     = 1'b0;
    assign tl_c_opcode    = 3'd0;
    assign tl_c_param     = 3'd0;
    assign tl_c_size      = 4'd0;
    assign tl_c_source    = '0;
    assign tl_c_address   = '0;
    assign tl_c_data      = '0;
    assign tl_c_corrupt   = 1'b0;
    assign tl_e_valid     = 1'b0;
    assign tl_e_bits_sink = '0;

    assign idle             = (outstanding == '0) && !r_a_valid && !r_rsp_valid;
    assign err_unexpected_d = r_err_unexp;
    assign err_opcode       = r_err_op;

    assign w_unused_inputs = ^{tl_b_valid, tl_b_param, tl_b_size, tl_b_source, tl_b_address,
                               tl_c_ready, tl_e_ready, tl_d_param, tl_d_size, tl_d_sink};

endmodule
